// File: rtl/if_fetch_queue_if.sv
// Fetch-to-decode queue bundle: fetch-side push, decode-side pop, flush and occupancy.
// The master drives (fetch/decode/branch side); the slave is the queue itself.
interface if_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             fetch_freeze;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, fetch_freeze, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, fetch_freeze, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction prefetch queue: circular FIFO of {pc, instr} pairs between fetch and decode,
// flushed on a taken branch and back-pressuring fetch through fetch_freeze when full.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             rst,
  if_fetch_queue_if.slave q
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("if_fetch_queue: DEPTH must be a power of two >= 2");
    end
  endgenerate

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t head;

  // Readiness depends only on registered occupancy, so there is no
  // combinational path from in_valid/out_ready to the handshake outputs.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = q.in_valid  & ~full  & ~q.flush;
  assign pop   = q.out_ready & ~empty & ~q.flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the storage array is reset here because the queue must come out of
      // reset with all entries cleared; without that, leave memories unreset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (q.flush) begin
      // Entries stay in place; count=0 makes them unreachable.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: q.in_pc, instr: q.in_instr};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  assign q.in_ready     = ~full;
  assign q.fetch_freeze = full;
  assign q.out_valid    = ~empty;
  // No bypass: an empty queue presents zeros rather than stale storage.
  assign q.out_pc       = empty ? 32'h0 : head.pc;
  assign q.out_instr    = empty ? 32'h0 : head.instr;
  assign q.count        = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the FIFO behaviour.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [63:0] model_q [$];

  if_fetch_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  if_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst_n),
    .q   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model_head();
    if (model_q.size() == 0) return 64'h0;
    return model_q[0];
  endfunction

  // Drive one cycle at the negedge, advance the model at the posedge, return at the next negedge.
  task automatic step(input logic f, input logic iv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic ordy);
    logic do_push;
    logic do_pop;
    bus.flush     = f;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    do_push = iv   && (model_q.size() < DEPTH) && !f;
    do_pop  = ordy && (model_q.size() != 0)    && !f;
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, ins});
    end
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, base + 32'(4 * i), ~(base + 32'(4 * i)), 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%0b want=0", bus.out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
    total++;
    if (bus.in_ready !== 1'b1 || bus.fetch_freeze !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%0b/%0b want=1/0", bus.in_ready, bus.fetch_freeze);
    end
    total++;
    if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin
      bad++; $display("FAIL reset_head got=%h/%h want=0/0", bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_fill_drain();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    push_n(4, 32'd4);
    total++;
    if (bus.count !== CNT_W'(4) || bus.in_ready !== 1'b0 || bus.fetch_freeze !== 1'b1) begin
      bad++; $display("FAIL fill_full got=%0d/%0b/%0b want=4/0/1", bus.count, bus.in_ready, bus.fetch_freeze);
    end
    step(1'b0, 1'b1, 32'd20, 32'hdead, 1'b0);
    total++;
    if (bus.count !== CNT_W'(4) || bus.out_pc !== 32'd4) begin
      bad++; $display("FAIL fill_ignored got=%0d/%0d want=4/4", bus.count, bus.out_pc);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * (i + 1)) || bus.out_instr !== ~32'(4 * (i + 1))) begin
        bad++; $display("FAIL drain_%0d got=%0b/%0d want=1/%0d", i, bus.out_valid, bus.out_pc, 4 * (i + 1));
      end
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== '0 || bus.out_pc !== 32'h0) begin
      bad++; $display("FAIL drain_empty got=%0b/%0d/%h want=0/0/0", bus.out_valid, bus.count, bus.out_pc);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    push_n(2, 32'd4);
    for (int k = 3; k <= 12; k++) begin
      total++;
      if (bus.count !== CNT_W'(2) || bus.out_pc !== 32'(4 * (k - 2))) begin
        bad++; $display("FAIL wrap_%0d got=%0d/%0d want=2/%0d", k, bus.count, bus.out_pc, 4 * (k - 2));
      end
      step(1'b0, 1'b1, 32'(4 * k), ~32'(4 * k), 1'b1);
    end
    total++;
    if (bus.count !== CNT_W'(2) || bus.out_pc !== 32'd44) begin
      bad++; $display("FAIL wrap_end got=%0d/%0d want=2/44", bus.count, bus.out_pc);
    end
  endtask

  task automatic test_full_pop();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    push_n(4, 32'h40);
    step(1'b0, 1'b1, 32'h50, 32'h1, 1'b1);
    total++;
    if (bus.count !== CNT_W'(3) || bus.in_ready !== 1'b1 || bus.fetch_freeze !== 1'b0) begin
      bad++; $display("FAIL full_pop got=%0d/%0b/%0b want=3/1/0", bus.count, bus.in_ready, bus.fetch_freeze);
    end
    total++;
    if (bus.out_pc !== 32'h44) begin bad++; $display("FAIL full_pop_head got=%h want=44", bus.out_pc); end
    // The 0x50 offer was refused, so the tail after two more pops must be 0x4c.
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    total++;
    if (bus.count !== CNT_W'(1) || bus.out_pc !== 32'h4c) begin
      bad++; $display("FAIL full_pop_tail got=%0d/%h want=1/4c", bus.count, bus.out_pc);
    end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    push_n(3, 32'h80);
    step(1'b1, 1'b1, 32'h200, 32'h2, 1'b1);
    total++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_pc !== 32'h0) begin
      bad++; $display("FAIL flush got=%0d/%0b/%0b/%h want=0/0/1/0", bus.count, bus.out_valid, bus.in_ready, bus.out_pc);
    end
    step(1'b0, 1'b1, 32'h100, 32'hcafe, 1'b0);
    total++;
    if (bus.count !== CNT_W'(1) || bus.out_pc !== 32'h100 || bus.out_instr !== 32'hcafe) begin
      bad++; $display("FAIL flush_push got=%0d/%h/%h want=1/100/cafe", bus.count, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    push_n(3, 32'h90);
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    total++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0
        || bus.in_ready !== 1'b1 || bus.fetch_freeze !== 1'b0) begin
      bad++; $display("FAIL reset_mid got=%0d/%0b/%h/%0b want=0/0/0/1", bus.count, bus.out_valid, bus.out_pc, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 32'h300, 32'h3, 1'b0);
    total++;
    if (bus.count !== CNT_W'(1) || bus.out_pc !== 32'h300) begin
      bad++; $display("FAIL reset_mid_push got=%0d/%h want=1/300", bus.count, bus.out_pc);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_head;
    int          exp_cnt;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(15) == 0, $urandom_range(3) != 0, $urandom, $urandom, $urandom_range(2) != 0);
      exp_head = model_head();
      exp_cnt  = model_q.size();
      total++;
      if (bus.count !== CNT_W'(exp_cnt) || bus.out_valid !== (exp_cnt != 0)
          || bus.in_ready !== (exp_cnt != DEPTH) || bus.fetch_freeze !== (exp_cnt == DEPTH)
          || bus.out_pc !== exp_head[63:32] || bus.out_instr !== exp_head[31:0]) begin
        bad++;
        $display("FAIL random_%0d got=%0d/%0b/%h/%h want=%0d/%0b/%h/%h", n, bus.count, bus.out_valid,
                 bus.out_pc, bus.out_instr, exp_cnt, exp_cnt != 0, exp_head[63:32], exp_head[31:0]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
